// File: rtl/stk_eng_arb_if.sv
// ----------------------------------------------------------------------------
// cfg_pkg / stk_eng_arb_if
//
// cfg_pkg holds the shared pipeline configuration. ENGS_N is the number of
// stack engines.
//
// stk_eng_arb_if bundles every non-clock, non-reset signal of the admission
// arbiter. The naming follows the arbiter's point of view: i_* are arbiter
// inputs and o_* are arbiter outputs.
//   Command group   : i_cmd_vld, i_cmd_push, o_cmd_ack, o_gnt_vld, o_gnt_engid
//   Allocator group : i_al_empty_r, i_al_busy_r, o_al_alloc
//   Writeback group : i_wrbk_vld_r, i_wrbk_engid_r
//   Status          : o_inflight_r, o_idle, o_err_r
//
// Modports:
//   slave  - the arbiter itself
//   master - the surrounding pipeline (engines, allocator, writeback)
// ----------------------------------------------------------------------------
package cfg_pkg;
  localparam int ENGS_N = 4;
endpackage

interface stk_eng_arb_if #(
  parameter int ENGS_N = cfg_pkg::ENGS_N
);
  localparam int ENGID_W = $clog2(ENGS_N);

  logic [ENGS_N-1:0]  i_cmd_vld;
  logic [ENGS_N-1:0]  i_cmd_push;
  logic [ENGS_N-1:0]  o_cmd_ack;
  logic               o_gnt_vld;
  logic [ENGID_W-1:0] o_gnt_engid;

  logic               i_al_empty_r;
  logic               i_al_busy_r;
  logic               o_al_alloc;

  logic               i_wrbk_vld_r;
  logic [ENGID_W-1:0] i_wrbk_engid_r;

  logic [ENGS_N-1:0]  o_inflight_r;
  logic               o_idle;
  logic               o_err_r;

  modport slave (
    input  i_cmd_vld, i_cmd_push, i_al_empty_r, i_al_busy_r,
           i_wrbk_vld_r, i_wrbk_engid_r,
    output o_cmd_ack, o_gnt_vld, o_gnt_engid, o_al_alloc,
           o_inflight_r, o_idle, o_err_r
  );

  modport master (
    output i_cmd_vld, i_cmd_push, i_al_empty_r, i_al_busy_r,
           i_wrbk_vld_r, i_wrbk_engid_r,
    input  o_cmd_ack, o_gnt_vld, o_gnt_engid, o_al_alloc,
           o_inflight_r, o_idle, o_err_r
  );
endinterface

// File: rtl/stk_eng_arb.sv
// ----------------------------------------------------------------------------
// stk_eng_arb
//
// Admission arbiter and hazard tracker for the stack-engine pipeline.
// Each cycle it grants at most one engine command. Selection is round-robin,
// starting at rr_q. A granted engine is locked until its writeback returns,
// so no engine ever has two commands in flight. A push request, which needs
// a free pointer, is only eligible while the allocator is neither empty nor
// busy.
//
// Ports:
//   clk     - sole clock, rising edge
//   arst_n  - asynchronous active-low reset
//   bus     - stk_eng_arb_if.slave. It carries the command, allocator,
//             writeback and status signals.
//
// Build option:
//   STK_ENG_ARB_WRBK_BYPASS_EN - when defined, a writeback unlocks its engine
//   for eligibility in the same cycle. This allows a same-cycle re-grant.
//   When undefined, eligibility uses only the registered lock mask.
// ----------------------------------------------------------------------------
module stk_eng_arb #(
  parameter int ENGS_N = cfg_pkg::ENGS_N
) (
  input  logic          clk,
  input  logic          arst_n,
  stk_eng_arb_if.slave  bus
);
  localparam int ENGID_W = $clog2(ENGS_N);

  // State
  logic [ENGS_N-1:0]  inflight_q, inflight_d;
  logic [ENGID_W-1:0] rr_q, rr_d;
  logic               err_q, err_d;

  // Combinational helpers
  logic               wb_in_range;
  logic [ENGS_N-1:0]  clr_vec;
  logic [ENGS_N-1:0]  lock_eff;
  logic [ENGS_N-1:0]  elig;
  logic               push_ok;
  logic [ENGS_N-1:0]  ack;
  logic               gnt_vld;
  logic [ENGID_W-1:0] gnt_id;
  int                 idx;

  // Ids at or above ENGS_N can only appear when ENGS_N is not a power of two.
  // Such writebacks never clear a lock; they only raise the error flag.
  assign wb_in_range = 32'(bus.i_wrbk_engid_r) < 32'(ENGS_N);

  // One-hot clear vector for the retiring engine.
  for (genvar gi = 0; gi < ENGS_N; gi++) begin : g_clr
    assign clr_vec[gi] = bus.i_wrbk_vld_r && wb_in_range &&
                         (32'(bus.i_wrbk_engid_r) == gi);
  end

`ifdef STK_ENG_ARB_WRBK_BYPASS_EN
  // An engine whose writeback arrives this cycle is already free to re-issue.
  assign lock_eff = inflight_q & ~clr_vec;
`else
  assign lock_eff = inflight_q;
`endif

  assign push_ok = ~(bus.i_al_empty_r | bus.i_al_busy_r);
  assign elig    = bus.i_cmd_vld & ~lock_eff &
                   (~bus.i_cmd_push | {ENGS_N{push_ok}});

  // Round-robin search: the first eligible engine at or above rr_q, wrapping.
  always_comb begin
    ack     = '0;
    gnt_vld = 1'b0;
    gnt_id  = '0;
    idx     = 0;
    for (int k = 0; k < ENGS_N; k++) begin
      idx = (int'(rr_q) + k) % ENGS_N;
      if (!gnt_vld && elig[idx]) begin
        gnt_vld = 1'b1;
        gnt_id  = ENGID_W'(idx);
      end
    end
    if (gnt_vld) begin
      ack[gnt_id] = 1'b1;
    end
  end

  // Next-state logic. The clear is applied before the set, so when both hit
  // the same engine (possible only under bypass) the engine stays locked.
  // A writeback that hits no locked bit is a protocol error. This includes an
  // out-of-range id, because clr_vec is empty in that case.
  always_comb begin
    inflight_d = (inflight_q & ~clr_vec) | ack;
    err_d      = err_q | (bus.i_wrbk_vld_r & ~(|(clr_vec & inflight_q)));
    rr_d       = rr_q;
    if (gnt_vld) begin
      rr_d = (gnt_id == ENGID_W'(ENGS_N - 1)) ? '0 : gnt_id + ENGID_W'(1);
    end
  end

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      inflight_q <= '0;
      rr_q       <= '0;
      err_q      <= 1'b0;
    end else begin
      inflight_q <= inflight_d;
      rr_q       <= rr_d;
      err_q      <= err_d;
    end
  end

  // Grant outputs are suppressed for as long as reset is held.
  assign bus.o_cmd_ack    = arst_n ? ack : '0;
  assign bus.o_gnt_vld    = arst_n & gnt_vld;
  assign bus.o_gnt_engid  = (arst_n && gnt_vld) ? gnt_id : '0;
  assign bus.o_al_alloc   = arst_n & gnt_vld & bus.i_cmd_push[gnt_id];

  assign bus.o_inflight_r = inflight_q;
  assign bus.o_idle       = (inflight_q == '0);
  assign bus.o_err_r      = err_q;
endmodule

// File: tb/tb_stk_eng_arb.sv
`timescale 1ns/1ps
module tb_stk_eng_arb;
  localparam int N = 4;
  localparam int W = $clog2(N);
`ifdef STK_ENG_ARB_WRBK_BYPASS_EN
  localparam bit BYPASS = 1'b1;
`else
  localparam bit BYPASS = 1'b0;
`endif

  logic clk = 1'b0;
  logic arst_n = 1'b0;
  always #5 clk = ~clk;

  stk_eng_arb_if #(.ENGS_N(N)) bus ();
  stk_eng_arb #(.ENGS_N(N)) dut (.clk(clk), .arst_n(arst_n), .bus(bus.slave));

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: a lock flag per engine, a round-robin start index and
  // a sticky error flag.
  bit m_lock[N];
  int m_rr;
  bit m_err;

  function automatic int model_pick();
    int e;
    bit freed;
    for (int k = 0; k < N; k++) begin
      e = (m_rr + k) % N;
      freed = BYPASS && bus.i_wrbk_vld_r && (int'(bus.i_wrbk_engid_r) == e);
      if (bus.i_cmd_vld[e] && (!m_lock[e] || freed) &&
          (!bus.i_cmd_push[e] || (!bus.i_al_empty_r && !bus.i_al_busy_r)))
        return e;
    end
    return -1;
  endfunction

  function automatic logic [N-1:0] model_locks();
    logic [N-1:0] v;
    for (int e = 0; e < N; e++) v[e] = m_lock[e];
    return v;
  endfunction

  task automatic model_reset();
    for (int e = 0; e < N; e++) m_lock[e] = 1'b0;
    m_rr = 0;
    m_err = 1'b0;
  endtask

  task automatic model_commit(input int g);
    int id;
    id = int'(bus.i_wrbk_engid_r);
    if (bus.i_wrbk_vld_r) begin
      if (id >= N || !m_lock[id]) m_err = 1'b1;
      else m_lock[id] = 1'b0;
    end
    if (g >= 0) begin
      m_lock[g] = 1'b1;
      m_rr = (g + 1) % N;
    end
  endtask

  task automatic set_in(input logic [N-1:0] vld, input logic [N-1:0] push,
                        input logic empty, input logic busy,
                        input logic wbv, input logic [W-1:0] wbid);
    bus.i_cmd_vld      = vld;
    bus.i_cmd_push     = push;
    bus.i_al_empty_r   = empty;
    bus.i_al_busy_r    = busy;
    bus.i_wrbk_vld_r   = wbv;
    bus.i_wrbk_engid_r = wbid;
    #1;
  endtask

  task automatic tick();
    int g;
    g = model_pick();
    model_commit(g);
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    set_in('0, '0, 1'b0, 1'b0, 1'b0, '0);
    arst_n = 1'b0;
    model_reset();
    @(posedge clk);
    #1;
    arst_n = 1'b1;
    #1;
  endtask

  task automatic test_reset();
    logic [N-1:0] exp_seq[3];
    exp_seq[0] = 4'b0010; exp_seq[1] = 4'b0100; exp_seq[2] = 4'b1000;
    set_in('1, '0, 1'b0, 1'b0, 1'b0, '0);
    arst_n = 1'b0;
    model_reset();
    #2;
    n_checks++; if (bus.o_cmd_ack !== 4'b0000) begin n_errors++; $display("FAIL reset_ack: got %b expected 0000", bus.o_cmd_ack); end
    n_checks++; if (bus.o_gnt_vld !== 1'b0) begin n_errors++; $display("FAIL reset_gnt_vld: got %b expected 0", bus.o_gnt_vld); end
    n_checks++; if (bus.o_inflight_r !== 4'b0000) begin n_errors++; $display("FAIL reset_inflight: got %b expected 0000", bus.o_inflight_r); end
    n_checks++; if (bus.o_idle !== 1'b1) begin n_errors++; $display("FAIL reset_idle: got %b expected 1", bus.o_idle); end
    n_checks++; if (bus.o_err_r !== 1'b0) begin n_errors++; $display("FAIL reset_err: got %b expected 0", bus.o_err_r); end
    @(posedge clk);
    #1;
    arst_n = 1'b1;
    #1;
    n_checks++; if (bus.o_cmd_ack !== 4'b0001) begin n_errors++; $display("FAIL reset_first_ack: got %b expected 0001", bus.o_cmd_ack); end
    tick();
    n_checks++; if (bus.o_inflight_r !== 4'b0001) begin n_errors++; $display("FAIL reset_first_lock: got %b expected 0001", bus.o_inflight_r); end
    for (int i = 0; i < 3; i++) begin
      n_checks++; if (bus.o_cmd_ack !== exp_seq[i]) begin n_errors++; $display("FAIL reset_seq_ack%0d: got %b expected %b", i, bus.o_cmd_ack, exp_seq[i]); end
      tick();
    end
    n_checks++; if (bus.o_cmd_ack !== 4'b0000) begin n_errors++; $display("FAIL reset_all_locked_ack: got %b expected 0000", bus.o_cmd_ack); end
    n_checks++; if (bus.o_inflight_r !== 4'b1111) begin n_errors++; $display("FAIL reset_all_locked: got %b expected 1111", bus.o_inflight_r); end
    n_checks++; if (bus.o_idle !== 1'b0) begin n_errors++; $display("FAIL reset_not_idle: got %b expected 0", bus.o_idle); end
    $display("test_reset done");
  endtask

  task automatic test_round_robin();
    do_reset();
    set_in(4'b0010, '0, 1'b0, 1'b0, 1'b0, '0);
    n_checks++; if (bus.o_cmd_ack !== 4'b0010) begin n_errors++; $display("FAIL rr_setup_ack: got %b expected 0010", bus.o_cmd_ack); end
    tick();
    set_in(4'b1001, '0, 1'b0, 1'b0, 1'b0, '0);
    n_checks++; if (bus.o_cmd_ack !== 4'b1000) begin n_errors++; $display("FAIL rr_ack3: got %b expected 1000", bus.o_cmd_ack); end
    n_checks++; if (bus.o_gnt_engid !== 2'd3) begin n_errors++; $display("FAIL rr_engid3: got %0d expected 3", bus.o_gnt_engid); end
    tick();
    n_checks++; if (bus.o_cmd_ack !== 4'b0001) begin n_errors++; $display("FAIL rr_ack0: got %b expected 0001", bus.o_cmd_ack); end
    n_checks++; if (bus.o_gnt_engid !== 2'd0) begin n_errors++; $display("FAIL rr_engid0: got %0d expected 0", bus.o_gnt_engid); end
    tick();
    n_checks++; if (bus.o_inflight_r !== 4'b1011) begin n_errors++; $display("FAIL rr_locks: got %b expected 1011", bus.o_inflight_r); end
    $display("test_round_robin done");
  endtask

  task automatic test_alloc_stall();
    do_reset();
    set_in(4'b0110, 4'b0010, 1'b1, 1'b0, 1'b0, '0);
    n_checks++; if (bus.o_cmd_ack !== 4'b0100) begin n_errors++; $display("FAIL stall_ack: got %b expected 0100", bus.o_cmd_ack); end
    n_checks++; if (bus.o_al_alloc !== 1'b0) begin n_errors++; $display("FAIL stall_alloc: got %b expected 0", bus.o_al_alloc); end
    tick();
    set_in(4'b0110, 4'b0010, 1'b0, 1'b0, 1'b0, '0);
    n_checks++; if (bus.o_cmd_ack !== 4'b0010) begin n_errors++; $display("FAIL unstall_ack: got %b expected 0010", bus.o_cmd_ack); end
    n_checks++; if (bus.o_al_alloc !== 1'b1) begin n_errors++; $display("FAIL unstall_alloc: got %b expected 1", bus.o_al_alloc); end
    n_checks++; if (bus.o_gnt_engid !== 2'd1) begin n_errors++; $display("FAIL unstall_engid: got %0d expected 1", bus.o_gnt_engid); end
    tick();
    set_in(4'b1000, 4'b1000, 1'b0, 1'b1, 1'b0, '0);
    n_checks++; if (bus.o_cmd_ack !== 4'b0000) begin n_errors++; $display("FAIL busy_ack: got %b expected 0000", bus.o_cmd_ack); end
    tick();
    $display("test_alloc_stall done");
  endtask

  task automatic test_lock_bypass();
    do_reset();
    set_in(4'b0001, '0, 1'b0, 1'b0, 1'b0, '0);
    n_checks++; if (bus.o_cmd_ack !== 4'b0001) begin n_errors++; $display("FAIL lock_c0_ack: got %b expected 0001", bus.o_cmd_ack); end
    tick();
    for (int c = 1; c < 5; c++) begin
      set_in(4'b0001, '0, 1'b0, 1'b0, 1'b0, '0);
      n_checks++; if (bus.o_cmd_ack !== 4'b0000) begin n_errors++; $display("FAIL lock_c%0d_ack: got %b expected 0000", c, bus.o_cmd_ack); end
      tick();
    end
    set_in(4'b0001, '0, 1'b0, 1'b0, 1'b1, 2'd0);
    n_checks++; if (bus.o_cmd_ack !== (BYPASS ? 4'b0001 : 4'b0000)) begin n_errors++; $display("FAIL lock_c5_ack: got %b expected %b", bus.o_cmd_ack, BYPASS ? 4'b0001 : 4'b0000); end
    tick();
    n_checks++; if (bus.o_inflight_r[0] !== BYPASS) begin n_errors++; $display("FAIL lock_c5_lock: got %b expected %b", bus.o_inflight_r[0], BYPASS); end
    set_in(4'b0001, '0, 1'b0, 1'b0, 1'b0, '0);
    n_checks++; if (bus.o_cmd_ack !== (BYPASS ? 4'b0000 : 4'b0001)) begin n_errors++; $display("FAIL lock_c6_ack: got %b expected %b", bus.o_cmd_ack, BYPASS ? 4'b0000 : 4'b0001); end
    tick();
    n_checks++; if (bus.o_inflight_r[0] !== 1'b1) begin n_errors++; $display("FAIL lock_final: got %b expected 1", bus.o_inflight_r[0]); end
    n_checks++; if (bus.o_err_r !== 1'b0) begin n_errors++; $display("FAIL lock_err: got %b expected 0", bus.o_err_r); end
    $display("test_lock_bypass done");
  endtask

  task automatic test_error();
    do_reset();
    set_in('0, '0, 1'b0, 1'b0, 1'b1, 2'd2);
    n_checks++; if (bus.o_err_r !== 1'b0) begin n_errors++; $display("FAIL err_before: got %b expected 0", bus.o_err_r); end
    tick();
    n_checks++; if (bus.o_err_r !== 1'b1) begin n_errors++; $display("FAIL err_set: got %b expected 1", bus.o_err_r); end
    n_checks++; if (bus.o_inflight_r !== 4'b0000) begin n_errors++; $display("FAIL err_mask: got %b expected 0000", bus.o_inflight_r); end
    set_in('0, '0, 1'b0, 1'b0, 1'b0, '0);
    tick(); tick(); tick();
    n_checks++; if (bus.o_err_r !== 1'b1) begin n_errors++; $display("FAIL err_sticky: got %b expected 1", bus.o_err_r); end
    do_reset();
    n_checks++; if (bus.o_err_r !== 1'b0) begin n_errors++; $display("FAIL err_cleared: got %b expected 0", bus.o_err_r); end
    $display("test_error done");
  endtask

  task automatic test_reset_midflight();
    do_reset();
    set_in(4'b1010, '0, 1'b0, 1'b0, 1'b0, '0);
    tick();
    tick();
    n_checks++; if (bus.o_inflight_r !== 4'b1010) begin n_errors++; $display("FAIL mid_setup: got %b expected 1010", bus.o_inflight_r); end
    set_in(4'b1111, 4'b1111, 1'b0, 1'b0, 1'b0, '0);
    #1;
    arst_n = 1'b0;
    model_reset();
    #1;
    n_checks++; if (bus.o_inflight_r !== 4'b0000) begin n_errors++; $display("FAIL mid_mask: got %b expected 0000", bus.o_inflight_r); end
    n_checks++; if (bus.o_idle !== 1'b1) begin n_errors++; $display("FAIL mid_idle: got %b expected 1", bus.o_idle); end
    n_checks++; if (bus.o_cmd_ack !== 4'b0000) begin n_errors++; $display("FAIL mid_ack: got %b expected 0000", bus.o_cmd_ack); end
    n_checks++; if (bus.o_al_alloc !== 1'b0) begin n_errors++; $display("FAIL mid_alloc: got %b expected 0", bus.o_al_alloc); end
    @(posedge clk);
    #1;
    arst_n = 1'b1;
    #1;
    $display("test_reset_midflight done");
  endtask

  task automatic test_random();
    int g;
    logic [N-1:0] vld, push;
    logic empty, busy, wbv;
    logic [W-1:0] wbid;
    int cand;
    do_reset();
    for (int cyc = 0; cyc < 400; cyc++) begin
      vld   = N'($urandom);
      push  = N'($urandom);
      empty = ($urandom_range(0, 3) == 0);
      busy  = ($urandom_range(0, 3) == 0);
      wbv   = 1'b0;
      wbid  = '0;
      if ($urandom_range(0, 2) == 0) begin
        cand = int'($urandom_range(0, N - 1));
        for (int k = 0; k < N; k++) begin
          if (m_lock[(cand + k) % N] && !wbv) begin
            wbv = 1'b1;
            wbid = W'((cand + k) % N);
          end
        end
      end
      if ($urandom_range(0, 99) < 3) begin
        wbv = 1'b1;
        wbid = W'($urandom_range(0, N - 1));
      end
      set_in(vld, push, empty, busy, wbv, wbid);
      g = model_pick();
      n_checks++; if (bus.o_cmd_ack !== ((g >= 0) ? (N'(1) << g) : N'(0))) begin n_errors++; $display("FAIL rnd_ack cyc%0d: got %b expected %b", cyc, bus.o_cmd_ack, (g >= 0) ? (N'(1) << g) : N'(0)); end
      n_checks++; if (bus.o_gnt_vld !== (g >= 0)) begin n_errors++; $display("FAIL rnd_gnt_vld cyc%0d: got %b expected %b", cyc, bus.o_gnt_vld, g >= 0); end
      n_checks++; if (bus.o_gnt_engid !== ((g >= 0) ? W'(g) : W'(0))) begin n_errors++; $display("FAIL rnd_engid cyc%0d: got %0d expected %0d", cyc, bus.o_gnt_engid, (g >= 0) ? g : 0); end
      n_checks++; if (bus.o_al_alloc !== ((g >= 0) && push[g])) begin n_errors++; $display("FAIL rnd_alloc cyc%0d: got %b expected %b", cyc, bus.o_al_alloc, (g >= 0) && push[g]); end
      tick();
      n_checks++; if (bus.o_inflight_r !== model_locks()) begin n_errors++; $display("FAIL rnd_locks cyc%0d: got %b expected %b", cyc, bus.o_inflight_r, model_locks()); end
      n_checks++; if (bus.o_idle !== (model_locks() == '0)) begin n_errors++; $display("FAIL rnd_idle cyc%0d: got %b expected %b", cyc, bus.o_idle, model_locks() == '0); end
      n_checks++; if (bus.o_err_r !== m_err) begin n_errors++; $display("FAIL rnd_err cyc%0d: got %b expected %b", cyc, bus.o_err_r, m_err); end
      if (cyc % 100 == 99) do_reset();
    end
    $display("test_random done");
  endtask

  initial begin
    set_in('0, '0, 1'b0, 1'b0, 1'b0, '0);
    model_reset();
    test_reset();
    test_round_robin();
    test_alloc_stall();
    test_lock_bypass();
    test_error();
    test_reset_midflight();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule

// File: doc/stk_eng_arb.md
# stk_eng_arb

Admission arbiter and hazard tracker for the stack-engine pipeline. It selects, each cycle, at most one of `cfg_pkg::ENGS_N` engine command requests using round-robin priority and issues the allocation strobe to the pointer allocator. It locks each granted engine until that engine's writeback returns, so no engine has two commands in flight. It sits in front of the lookup stage and drives the LK valid/engid capture and the allocator handshake.

## Interface
- `ENGS_N`, default `cfg_pkg::ENGS_N` (4): number of requesting engines.
- `ENGID_W`, default `$clog2(ENGS_N)`: engine id width (derived; never overridden).
- `clk`  in  1  sole clock; all state is updated on the rising edge.
- `arst_n`  in  1  reset, asynchronous, active-low.
- `i_cmd_vld`  in  ENGS_N  per-engine request; level, held until acked.
- `i_cmd_push`  in  ENGS_N  per-engine flag: the request needs a free pointer.
- `o_cmd_ack`  out  ENGS_N  one-hot grant; combinational.
- `o_gnt_vld`  out  1  a grant occurred this cycle (OR of `o_cmd_ack`).
- `o_gnt_engid`  out  ENGID_W  encoded id of the granted engine; 0 when `o_gnt_vld`=0.
- `i_al_empty_r`  in  1  free list empty.
- `i_al_busy_r`  in  1  allocator not ready.
- `o_al_alloc`  out  1  pop a pointer; equals `o_gnt_vld & i_cmd_push[o_gnt_engid]`.
- `i_wrbk_vld_r`  in  1  writeback retires a command.
- `i_wrbk_engid_r`  in  ENGID_W  engine id of the retiring command.
- `o_inflight_r`  out  ENGS_N  per-engine lock mask; reset 0.
- `o_idle`  out  1  `o_inflight_r == 0`; reset 1.
- `o_err_r`  out  1  sticky protocol error; reset 0.

## Operation
- **Eligibility.** An engine is eligible when all three hold:
  - `i_cmd_vld[e]` is high;
  - `o_inflight_r[e]` is 0, or it is being cleared this cycle (see Configuration);
  - `i_cmd_push[e]` is 0, or both `i_al_empty_r` and `i_al_busy_r` are 0.
- **Selection.** Pick the first eligible engine searching upward from `rr_r` and wrapping modulo ENGS_N.
  - `rr_r` resets to 0.
  - On a grant to e, `rr_r` <= (e+1) mod ENGS_N.
  - With no grant, `rr_r` holds.
- **Lock set.** On a grant to e, `o_inflight_r[e]` is set on the next edge.
- **Lock clear.** On `i_wrbk_vld_r`, `o_inflight_r[i_wrbk_engid_r]` is cleared on the next edge.
- **Same-engine set and clear.** A set and a clear for the same engine in the same cycle can only occur under bypass. The set wins, so the engine stays locked.
- **Error.** A writeback for an engine whose lock bit is 0 sets `o_err_r`. The lock mask is unchanged and `o_err_r` clears only on reset.
- **Out-of-range id.** When `i_wrbk_engid_r` ≥ ENGS_N, the writeback is ignored and `o_err_r` is set.
- **Reset.** Asserting `arst_n` mid-operation clears all locks and `rr_r` immediately. While `arst_n`=0, `o_cmd_ack`, `o_gnt_vld` and `o_al_alloc` are forced to 0.

## Timing
- Request to ack: 0 cycles (combinational in the request cycle).
- `o_inflight_r` is visible 1 cycle after the grant.
- A requester sees its ack in cycle N and drops or changes its request in cycle N+1.
- Back-to-back grants to different engines: one per cycle.
- Same-engine re-grant, without bypass: no earlier than 1 cycle after `i_wrbk_vld_r` for that engine.
- Allocator stall: pushes are blocked for every cycle in which `i_al_empty_r` or `i_al_busy_r` is high. Non-push requests are still granted in those cycles.
- Fairness: a continuously eligible engine is granted within ENGS_N grants.

## Configuration
- Macro: `STK_ENG_ARB_WRBK_BYPASS_EN`.
- **Defined.** A writeback for engine e in cycle N makes e eligible in cycle N, so a re-grant can occur in the same cycle as the writeback. This saves 1 cycle per command for a single-engine stream.
- **Undefined.** Eligibility uses only the registered `o_inflight_r`, so the earliest re-grant is cycle N+1.
- In both builds the lock-mask update rules above are unchanged.

## Test plan
- **Reset.** Assert and release reset with all `i_cmd_vld`=1 and no pushes.
  - Cycle 0: ack `4'b0001`; cycle 1: `o_inflight_r`=`0001`.
  - The next grants are 1, 2, 3, then nothing until writebacks return.
- **Round-robin.** With `rr_r`=2, engines 0 and 3 request → engine 3 is granted, then `rr_r`=0 and engine 0 is granted next cycle.
- **Allocator stall.** Engine 1 push with `i_al_empty_r`=1 and engine 2 non-push → engine 2 is granted and `o_al_alloc`=0. Deasserting `i_al_empty_r` then grants engine 1 with `o_al_alloc`=1.
- **Lock and bypass.**
  - Engine 0 granted; writeback for id 0 in cycle 5 with engine 0 requesting.
  - Ack in cycle 5 with the macro defined, cycle 6 without.
  - `o_inflight_r[0]`=1 afterwards in both builds.
- **Error.** Writeback for unlocked engine 2 → `o_err_r`=1 next cycle and `o_inflight_r` is unchanged. `o_err_r` stays set until reset.
- **Reset mid-flight.** `arst_n` low with `o_inflight_r`=`1010` → mask reads 0 and `o_idle`=1 immediately, without waiting for an edge.
